// File: rtl/trap_csr_unit.sv
// ---------------------------------------------------------------------------
// trap_csr_unit
//
// Supervisor trap CSR block. Owns STATUS, SCAUSE, INTMASK, SEPC and STVEC,
// which the combinational exception controller reads. This block is the
// other end of that interface. It latches interrupt and exception requests
// into sticky SCAUSE bits and saves the PC on trap entry. On SRET it clears
// EXL and the serviced cause bit.
//
// Optional feature macro: TRAP_TIMER_EN
//   When defined, TIME is a free-running counter compared against TIMECMP.
//   A match sets SCAUSE[0] and wraps TIME to 0.
//   When undefined, there is no counter, and addresses 4/5 read 0 and
//   ignore writes.
//
// Ports
//   clk            in   1   system clock, all state on rising edge
//   rstn           in   1   synchronous active-low reset
//   src_req        in   5   level requests for causes 3..7 (bit k -> SCAUSE[k+3])
//   illegal_instr  in   1   pulse from decode, sets SCAUSE[1]
//   ecall          in   1   pulse from decode, sets SCAUSE[2]
//   exl_set        in   1   trap-taken strobe from exception controller
//   int_pend       in   3   encoded cause being taken, valid with exl_set
//   pc             in  32   PC of the instruction to resume
//   sret           in   1   return-from-handler pulse
//   csr_we         in   1   CSR write enable
//   csr_addr       in   3   CSR select
//   csr_wdata      in  32   CSR write data
//   csr_rdata      out 32   CSR read data (combinational)
//   status         out  8   bit1 IE, bit0 EXL, bits 7:2 scratch
//   scause         out  8   sticky one-hot pending causes
//   intmask        out  8   per-cause enable
//   sepc           out 32   saved PC
//   stvec          out 32   handler base address
//   dbg_state      out  1   FSM state (0 RUN, 1 HANDLER)
//
// Handshake note: exl_set/int_pend and sret are single-cycle strobes with no
// back-pressure. A strobe is consumed on the rising edge where it is high,
// and only if the FSM is in the state that accepts it. Otherwise it is
// dropped.
// ---------------------------------------------------------------------------
module trap_csr_unit (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  src_req,
  input  logic        illegal_instr,
  input  logic        ecall,
  input  logic        exl_set,
  input  logic [2:0]  int_pend,
  input  logic [31:0] pc,
  input  logic        sret,
  input  logic        csr_we,
  input  logic [2:0]  csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic [7:0]  status,
  output logic [7:0]  scause,
  output logic [7:0]  intmask,
  output logic [31:0] sepc,
  output logic [31:0] stvec,
  output logic        dbg_state
);

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_HANDLER = 1'b1
  } state_e;

  localparam logic [2:0] A_STATUS  = 3'd0;
  localparam logic [2:0] A_INTMASK = 3'd1;
  localparam logic [2:0] A_SCAUSE  = 3'd2;
  localparam logic [2:0] A_STVEC   = 3'd3;
  localparam logic [2:0] A_TIMECMP = 3'd4;
  localparam logic [2:0] A_TIME    = 3'd5;
  localparam logic [2:0] A_SEPC    = 3'd6;

  state_e      state_q, state_d;
  logic [2:0]  saved_cause_q, saved_cause_d;
  logic [7:0]  status_q, status_d;
  logic [7:0]  scause_q, scause_d;
  logic [7:0]  intmask_q, intmask_d;
  logic [31:0] sepc_q, sepc_d;
  logic [31:0] stvec_q, stvec_d;

  logic        trap_enter;
  logic        trap_return;
  logic        timer_hit;
  logic [7:0]  cause_set;
  logic [7:0]  cause_clr;

  // ------------------------------------------------------------------------
  // Optional timer
  // ------------------------------------------------------------------------
`ifdef TRAP_TIMER_EN
  logic [31:0] time_q, time_d;
  logic [31:0] timecmp_q, timecmp_d;

  assign timer_hit = (time_q == timecmp_q);

  always_comb begin
    timecmp_d = timecmp_q;
    time_d    = time_q + 32'd1;
    if (timer_hit) begin
      time_d = 32'd0;
    end
    // Writing TIMECMP restarts the count so the new compare is measured
    // from the write.
    if (csr_we && csr_addr == A_TIMECMP) begin
      timecmp_d = csr_wdata;
      time_d    = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      time_q    <= 32'd0;
      timecmp_q <= 32'hFFFF_FFFF;
    end else begin
      time_q    <= time_d;
      timecmp_q <= timecmp_d;
    end
  end
`else
  assign timer_hit = 1'b0;
`endif

  // ------------------------------------------------------------------------
  // Trap FSM and register next-state
  // ------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    saved_cause_d = saved_cause_q;
    trap_enter    = 1'b0;
    trap_return   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (exl_set) begin
          trap_enter    = 1'b1;
          saved_cause_d = int_pend;
          state_d       = ST_HANDLER;
        end
      end
      ST_HANDLER: begin
        // exl_set is ignored here, so an sret in the same cycle wins.
        if (sret) begin
          trap_return = 1'b1;
          state_d     = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    status_d  = status_q;
    intmask_d = intmask_q;
    sepc_d    = sepc_q;
    stvec_d   = stvec_q;

    if (csr_we) begin
      case (csr_addr)
        A_STATUS:  status_d  = csr_wdata[7:0];
        A_INTMASK: intmask_d = csr_wdata[7:0];
        A_STVEC:   stvec_d   = {csr_wdata[31:2], 2'b00};
        A_SEPC:    sepc_d    = csr_wdata;
        default:   ;
      endcase
    end

    // The FSM owns EXL. On a collision it overrides only bit 0 of a
    // STATUS write.
    if (trap_enter) begin
      status_d[0] = 1'b1;
      sepc_d      = pc;
    end
    if (trap_return) begin
      status_d[0] = 1'b0;
    end
  end

  // SCAUSE: set wins over clear on the same bit.
  always_comb begin
    cause_set = {src_req, ecall, illegal_instr, timer_hit};
    cause_clr = 8'd0;
    if (trap_return) begin
      cause_clr[saved_cause_q] = 1'b1;
    end
    if (csr_we && csr_addr == A_SCAUSE) begin
      cause_clr = cause_clr | csr_wdata[7:0];
    end
    scause_d = (scause_q & ~cause_clr) | cause_set;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= ST_RUN;
      saved_cause_q <= 3'd0;
      status_q      <= 8'd0;
      scause_q      <= 8'd0;
      intmask_q     <= 8'd0;
      sepc_q        <= 32'd0;
      stvec_q       <= 32'd0;
    end else begin
      state_q       <= state_d;
      saved_cause_q <= saved_cause_d;
      status_q      <= status_d;
      scause_q      <= scause_d;
      intmask_q     <= intmask_d;
      sepc_q        <= sepc_d;
      stvec_q       <= stvec_d;
    end
  end

  // ------------------------------------------------------------------------
  // CSR read mux
  // ------------------------------------------------------------------------
  always_comb begin
    csr_rdata = 32'd0;
    case (csr_addr)
      A_STATUS:  csr_rdata = {24'd0, status_q};
      A_INTMASK: csr_rdata = {24'd0, intmask_q};
      A_SCAUSE:  csr_rdata = {24'd0, scause_q};
      A_STVEC:   csr_rdata = stvec_q;
`ifdef TRAP_TIMER_EN
      A_TIMECMP: csr_rdata = timecmp_q;
      A_TIME:    csr_rdata = time_q;
`else
      A_TIMECMP: csr_rdata = 32'd0;
      A_TIME:    csr_rdata = 32'd0;
`endif
      A_SEPC:    csr_rdata = sepc_q;
      default:   csr_rdata = 32'd0;
    endcase
  end

  assign status    = status_q;
  assign scause    = scause_q;
  assign intmask   = intmask_q;
  assign sepc      = sepc_q;
  assign stvec     = stvec_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_trap_csr_unit.sv
module tb_trap_csr_unit;

  logic        clk;
  logic        rstn;
  logic [4:0]  src_req;
  logic        illegal_instr;
  logic        ecall;
  logic        exl_set;
  logic [2:0]  int_pend;
  logic [31:0] pc;
  logic        sret;
  logic        csr_we;
  logic [2:0]  csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic [7:0]  status;
  logic [7:0]  scause;
  logic [7:0]  intmask;
  logic [31:0] sepc;
  logic [31:0] stvec;
  logic        dbg_state;

  int checks;
  int errors;

  trap_csr_unit dut (
    .clk           (clk),
    .rstn          (rstn),
    .src_req       (src_req),
    .illegal_instr (illegal_instr),
    .ecall         (ecall),
    .exl_set       (exl_set),
    .int_pend      (int_pend),
    .pc            (pc),
    .sret          (sret),
    .csr_we        (csr_we),
    .csr_addr      (csr_addr),
    .csr_wdata     (csr_wdata),
    .csr_rdata     (csr_rdata),
    .status        (status),
    .scause        (scause),
    .intmask       (intmask),
    .sepc          (sepc),
    .stvec         (stvec),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge. Outputs are checked
  // at the same point, after the edge has settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    src_req       = 5'd0;
    illegal_instr = 1'b0;
    ecall         = 1'b0;
    exl_set       = 1'b0;
    int_pend      = 3'd0;
    pc            = 32'd0;
    sret          = 1'b0;
    csr_we        = 1'b0;
    csr_addr      = 3'd0;
    csr_wdata     = 32'd0;
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    csr_we    = 1'b1;
    csr_addr  = a;
    csr_wdata = d;
    tick();
    csr_we    = 1'b0;
    csr_wdata = 32'd0;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    check(tag, csr_rdata, exp);
  endtask

  task automatic enter_trap(input logic [2:0] cause, input logic [31:0] p);
    exl_set  = 1'b1;
    int_pend = cause;
    pc       = p;
    tick();
    exl_set  = 1'b0;
  endtask

  task automatic pulse_sret();
    sret = 1'b1;
    tick();
    sret = 1'b0;
  endtask

  logic [31:0] exp_timecmp;

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;

    // ---- reset state ----
`ifdef TRAP_TIMER_EN
    exp_timecmp = 32'hFFFF_FFFF;
`else
    exp_timecmp = 32'd0;
`endif
    check("rst_status", {24'd0, status}, 32'd0);
    check("rst_scause", {24'd0, scause}, 32'd0);
    check("rst_intmask", {24'd0, intmask}, 32'd0);
    check("rst_sepc", sepc, 32'd0);
    check("rst_stvec", stvec, 32'd0);
    check("rst_state", {31'd0, dbg_state}, 32'd0);
    read_check("rst_rd0", 3'd0, 32'd0);
    read_check("rst_rd1", 3'd1, 32'd0);
    read_check("rst_rd2", 3'd2, 32'd0);
    read_check("rst_rd3", 3'd3, 32'd0);
    read_check("rst_rd4", 3'd4, exp_timecmp);
    read_check("rst_rd5", 3'd5, 32'd0);
    read_check("rst_rd6", 3'd6, 32'd0);

    // ---- ecall -> trap -> sret ----
    tick();
    ecall = 1'b1;
    tick();
    ecall = 1'b0;
    check("ecall_set", {24'd0, scause}, 32'h04);
    enter_trap(3'd2, 32'h0000_0100);
    check("entry_sepc", sepc, 32'h100);
    check("entry_status", {24'd0, status}, 32'h01);
    check("entry_state", {31'd0, dbg_state}, 32'd1);

    // exl_set is ignored in HANDLER
    enter_trap(3'd5, 32'h0000_0200);
    check("hnd_sepc_kept", sepc, 32'h100);
    check("hnd_state", {31'd0, dbg_state}, 32'd1);

    pulse_sret();
    check("ret_status", {24'd0, status}, 32'h00);
    check("ret_scause", {24'd0, scause}, 32'h00);
    check("ret_state", {31'd0, dbg_state}, 32'd0);

    // sret in RUN does nothing
    pulse_sret();
    check("run_sret_status", {24'd0, status}, 32'h00);
    check("run_sret_state", {31'd0, dbg_state}, 32'd0);

    // ---- set beats SRET clear on the same bit ----
    ecall = 1'b1;
    tick();
    ecall = 1'b0;
    enter_trap(3'd2, 32'h0000_0300);
    check("t2_sepc", sepc, 32'h300);
    sret  = 1'b1;
    ecall = 1'b1;
    tick();
    sret  = 1'b0;
    ecall = 1'b0;
    check("sret_ecall_scause", {24'd0, scause}, 32'h04);
    check("sret_ecall_state", {31'd0, dbg_state}, 32'd0);

    // ---- illegal + src_req, then W1C ----
    illegal_instr = 1'b1;
    src_req       = 5'b00001;
    tick();
    illegal_instr = 1'b0;
    src_req       = 5'd0;
    check("multi_set", {24'd0, scause}, 32'h0E);
    csr_write(3'd2, 32'h06);
    check("w1c", {24'd0, scause}, 32'h08);
    read_check("rd_scause", 3'd2, 32'h08);

    // W1C and a held request on the same bit: set wins
    src_req = 5'b00001;
    csr_write(3'd2, 32'h08);
    src_req = 5'd0;
    check("w1c_vs_set", {24'd0, scause}, 32'h08);

    // ---- STVEC alignment ----
    csr_write(3'd3, 32'h0000_1003);
    check("stvec", stvec, 32'h1000);
    read_check("rd_stvec", 3'd3, 32'h1000);

    // ---- STATUS collisions ----
    csr_write(3'd0, 32'h0000_00FE);
    check("status_wr", {24'd0, status}, 32'hFE);
    csr_we    = 1'b1;
    csr_addr  = 3'd0;
    csr_wdata = 32'h0000_00A4;
    enter_trap(3'd3, 32'h0000_0400);
    csr_we    = 1'b0;
    check("coll_entry_status", {24'd0, status}, 32'hA5);
    check("coll_entry_sepc", sepc, 32'h400);
    csr_we    = 1'b1;
    csr_addr  = 3'd0;
    csr_wdata = 32'h0000_0013;
    pulse_sret();
    csr_we    = 1'b0;
    check("coll_ret_status", {24'd0, status}, 32'h12);
    check("coll_ret_scause", {24'd0, scause}, 32'h00);

    // ---- plain registers ----
    csr_write(3'd1, 32'h0000_005A);
    check("intmask", {24'd0, intmask}, 32'h5A);
    read_check("rd_intmask", 3'd1, 32'h5A);
    csr_write(3'd6, 32'hDEAD_BEEF);
    check("sepc_wr", sepc, 32'hDEAD_BEEF);
    read_check("rd_sepc", 3'd6, 32'hDEAD_BEEF);
    read_check("rd_addr7", 3'd7, 32'd0);
    read_check("rd_status", 3'd0, 32'h12);

    // ---- timer ----
`ifdef TRAP_TIMER_EN
    csr_write(3'd4, 32'd10);
    read_check("tmr_cmp", 3'd4, 32'd10);
    read_check("tmr_time0", 3'd5, 32'd0);
    for (int i = 1; i <= 10; i++) tick();
    check("tmr_before", {31'd0, scause[0]}, 32'd0);
    read_check("tmr_time10", 3'd5, 32'd10);
    tick();
    check("tmr_hit", {31'd0, scause[0]}, 32'd1);
    read_check("tmr_wrap", 3'd5, 32'd0);
    csr_write(3'd2, 32'h01);
    check("tmr_w1c", {31'd0, scause[0]}, 32'd0);
`else
    csr_write(3'd4, 32'd10);
    csr_write(3'd5, 32'd77);
    for (int i = 0; i < 12; i++) tick();
    check("notmr_scause0", {31'd0, scause[0]}, 32'd0);
    read_check("notmr_rd4", 3'd4, 32'd0);
    read_check("notmr_rd5", 3'd5, 32'd0);
`endif

    // ---- reset mid-handler ----
    ecall = 1'b1;
    enter_trap(3'd2, 32'h0000_0500);
    ecall = 1'b0;
    check("pre_rst_state", {31'd0, dbg_state}, 32'd1);
    rstn      = 1'b0;
    sret      = 1'b1;
    ecall     = 1'b1;
    csr_we    = 1'b1;
    csr_addr  = 3'd1;
    csr_wdata = 32'hFF;
    tick();
    idle_inputs();
    rstn = 1'b1;
    check("mid_rst_state", {31'd0, dbg_state}, 32'd0);
    check("mid_rst_status", {24'd0, status}, 32'd0);
    check("mid_rst_scause", {24'd0, scause}, 32'd0);
    check("mid_rst_intmask", {24'd0, intmask}, 32'd0);
    check("mid_rst_sepc", sepc, 32'd0);
    check("mid_rst_stvec", stvec, 32'd0);
    read_check("mid_rst_rd4", 3'd4, exp_timecmp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_csr_unit.md
# trap_csr_unit

Supervisor trap CSR block: owns the STATUS, SCAUSE, INTMASK, SEPC and STVEC registers that the combinational exception controller reads, and is the other end of that interface. Latches interrupt/exception requests into sticky SCAUSE bits and saves the PC on trap entry. Clears EXL and the serviced cause bit on SRET. Sits in the CPU beside the register file, fed by decode (ecall/illegal/sret), the PC register and the exception controller's EXL_Set/INT_PEND outputs.

## Interface
- No parameters.
- clk  in  1  system clock, all state on rising edge
- rstn  in  1  synchronous, active-low reset
- src_req  in  5  level requests for reserved causes 3..7 (bit k → SCAUSE[k+3])
- illegal_instr  in  1  one-cycle pulse from decode
- ecall  in  1  one-cycle pulse from decode
- exl_set  in  1  trap-taken strobe from exception controller
- int_pend  in  3  encoded cause being taken, valid with exl_set
- pc  in  32  PC of the instruction to resume
- sret  in  1  one-cycle return-from-handler pulse
- csr_we  in  1  CSR write enable
- csr_addr  in  3  CSR select
- csr_wdata  in  32  CSR write data
- csr_rdata  out  32  CSR read data (combinational)
- status  out  8  bit1 IE, bit0 EXL, bits 7:2 read/write scratch
- scause  out  8  sticky one-hot pending causes
- intmask  out  8  per-cause enable
- sepc  out  32  saved PC
- stvec  out  32  handler base address

## Operation
- Cause encoding: index i ↔ SCAUSE[i] ↔ int_pend==i. 0 timer, 1 illegal instr, 2 ecall, 3..7 reserved.
- SCAUSE set sources per cycle: timer match (bit0), illegal_instr (bit1), ecall (bit2), src_req[4:0] (bits 7:3). Bits stay set until cleared.
- SCAUSE clear sources:
  - SRET clears the saved cause bit.
  - CSR write to addr 2 is write-1-to-clear on bits 7:0.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- FSM, two states:
  - RUN, exl_set=1: sepc←pc, status[0]←1, saved_cause←int_pend, go to HANDLER.
  - HANDLER: exl_set is ignored.
  - HANDLER, sret=1: status[0]←0, clear scause[saved_cause], go to RUN.
  - RUN, sret=1: ignored, no state change.
- CSR map, writes take full 8/32 bits:
  - 0 STATUS (8)
  - 1 INTMASK (8)
  - 2 SCAUSE (read; W1C)
  - 3 STVEC (32, bits 1:0 forced 0)
  - 4 TIMECMP (32)
  - 5 TIME (32, read-only)
  - 6 SEPC (32)
  - 7 reads 0
- 8-bit registers read zero-extended.
- Collision: CSR write to STATUS in the same cycle as trap entry or return. Bit0 takes the FSM value; the other bits take the write.

## Timing
- All outputs are registered except csr_rdata. Effects of exl_set, sret, source pulses and CSR writes are visible on the next cycle.
- Source pulse at cycle n → scause bit high from n+1. The exception controller can therefore signal at n+1.
- Trap entry and return each take 1 cycle. sret and exl_set in the same cycle in HANDLER: sret is processed and exl_set is ignored.
- Reset values:
  - status=0, intmask=0, scause=0, sepc=0, stvec=0
  - TIME=0, TIMECMP=0xFFFF_FFFF
  - FSM=RUN, saved_cause=0, csr_rdata reflects the reset registers
- Reset asserted mid-handler returns to RUN with all registers cleared, regardless of other inputs that cycle.

## Configuration
- TRAP_TIMER_EN defined:
  - TIME is a 32-bit free-running counter, +1 per cycle.
  - When TIME==TIMECMP, scause[0] is set next cycle and TIME wraps to 0.
  - 0xFFFF_FFFF wraps to 0 naturally.
  - A write to TIMECMP also resets TIME to 0.
- TRAP_TIMER_EN undefined:
  - No counter. scause[0] is never set by hardware; W1C still works.
  - Addr 4/5 read 0, and writes to them are ignored.

## Test plan
- Reset, then read addr 0–6 → all 0 except TIMECMP=0xFFFF_FFFF; status=0, FSM RUN.
- ecall pulse at cycle 5 → scause=0x04 at cycle 6. Then exl_set=1, int_pend=2, pc=0x0000_0100 → next cycle sepc=0x100, status[0]=1. sret → status[0]=0, scause=0x00.
- In HANDLER, pulse exl_set with pc=0x200 → sepc stays 0x100. Pulse sret while in RUN → no change.
- ecall pulse in the same cycle as an SRET that services cause 2 → scause[2] remains 1.
- CSR write addr 2 data 0x06 with scause=0x0E → scause=0x08. Write addr 3 data 0x1003 → stvec=0x1000.
- TRAP_TIMER_EN: write TIMECMP=10 → scause[0] rises 11 cycles after the write and TIME reads 0 then. Without the macro → scause[0] stays 0 and addr 5 reads 0.
